// File: rtl/uart_pkg.sv
// Shared definitions for the framed UART receiver: parity modes, FSM state
// encoding and the three-input majority helper.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_maj3.sv
// Three-sample majority voter on samp_clk ticks. mid_o is the centre sample, so
// a decision taken when the FSM sees mid-bit on mid_o spans mid-1, mid, mid+1.
module uart_maj3
  import uart_pkg::*;
(
  input  logic clk_i,
  input  logic reset_i,
  input  logic en_i,
  input  logic d_i,
  output logic mid_o,
  output logic maj_o
);

  logic [1:0] hist_q;
  logic [1:0] hist_d;

  // next sample history
  always_comb begin
    hist_d = hist_q;
    if (en_i) begin
      hist_d = {hist_q[0], d_i};
    end else begin
      hist_d = hist_q;
    end
  end

  // history register, reset to the normalised idle level
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      hist_q <= 2'b11;
    end else begin
      hist_q <= hist_d;
    end
  end

  assign mid_o = hist_q[0];
  assign maj_o = maj3(hist_q[1], hist_q[0], d_i);

endmodule

// File: rtl/uart_rx_framed.sv
// Oversampling UART receiver with optional parity, 1 or 2 stop bits, optional
// line inversion, and framing/parity error reporting.
module uart_rx_framed
  import uart_pkg::*;
#(
  parameter int Oversample = 3,
  parameter int Width      = 8,
  parameter int Parity     = 0,
  parameter int Stop       = 1,
  parameter int Invert     = 1
) (
  input  logic             ref_clk,
  input  logic             reset,
  input  logic             samp_clk,
  input  logic             in,
  output logic             ready,
  output logic             bit_clk,
  output logic [Width-1:0] out,
  output logic             perr,
  output logic             ferr
);

  localparam int                    BW        = $clog2(Width + 1);
  localparam logic                  INV       = (Invert != 0);
  localparam logic                  IDLE_RAW  = ~INV;
  localparam logic [Oversample-1:0] CNT_MID   = Oversample'((1 << (Oversample - 1)) - 1);
  localparam logic [Oversample-1:0] CNT_LAST  = '1;
  localparam logic [Oversample-1:0] CNT_ONE   = Oversample'(1);
  localparam logic [BW-1:0]         BIT_LAST  = BW'(Width - 1);
  localparam logic [BW-1:0]         STOP_LAST = BW'(Stop - 1);
  localparam logic [BW-1:0]         BIT_ONE   = BW'(1);

  logic sync1_q, sync2_q;
  logic line_s, mid_s, maj_s, perr_calc_s;
  state_t state_q, state_d;
  logic [Oversample-1:0] tick_q, tick_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [Width-1:0] shift_q, shift_d, out_q, out_d;
  logic par_q, par_d, facc_q, facc_d, hold_q, hold_d;
  logic ready_q, ready_d, bclk_q, bclk_d, perr_q, perr_d, ferr_q, ferr_d;

  // two-flop synchronizer on the raw line
  always_ff @(posedge ref_clk) begin
    if (reset) begin
      sync1_q <= IDLE_RAW;
      sync2_q <= IDLE_RAW;
    end else begin
      sync1_q <= in;
      sync2_q <= sync1_q;
    end
  end

  assign line_s = sync2_q ^ INV;

  uart_maj3 u_maj (
    .clk_i  (ref_clk),
    .reset_i(reset),
    .en_i   (samp_clk),
    .d_i    (line_s),
    .mid_o  (mid_s),
    .maj_o  (maj_s)
  );

  // parity check over the assembled word and received parity bit
  always_comb begin
    case (Parity)
      PAR_ODD:  perr_calc_s = ~((^shift_q) ^ par_q);
      PAR_EVEN: perr_calc_s = (^shift_q) ^ par_q;
      default:  perr_calc_s = 1'b0;
    endcase
  end

  // frame FSM; everything advances only on samp_clk ticks
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    facc_d  = facc_q;
    hold_d  = hold_q;
    out_d   = out_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    ready_d = 1'b0;
    bclk_d  = 1'b0;
    if (samp_clk) begin
      tick_d = tick_q + CNT_ONE;
      case (state_q)
        ST_IDLE: begin
          tick_d = '0;
          if (hold_q) begin
            // after a break, wait for the line to go idle before re-arming
            hold_d = ~mid_s;
          end else if (!mid_s) begin
            state_d = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_START: begin
          if (tick_q == CNT_MID) begin
            tick_d  = '0;
            bit_d   = '0;
            facc_d  = 1'b0;
            state_d = mid_s ? ST_IDLE : ST_DATA;
          end else begin
            state_d = ST_START;
          end
        end
        ST_DATA: begin
          if (tick_q == CNT_LAST) begin
            shift_d = {maj_s, shift_q[Width-1:1]};
            bclk_d  = 1'b1;
            if (bit_q == BIT_LAST) begin
              bit_d   = '0;
              state_d = (Parity != PAR_NONE) ? ST_PARITY : ST_STOP;
            end else begin
              bit_d = bit_q + BIT_ONE;
            end
          end else begin
            state_d = ST_DATA;
          end
        end
        ST_PARITY: begin
          if (tick_q == CNT_LAST) begin
            par_d   = maj_s;
            state_d = ST_STOP;
          end else begin
            state_d = ST_PARITY;
          end
        end
        ST_STOP: begin
          if (tick_q == CNT_LAST) begin
            facc_d = facc_q | ~maj_s;
            if (bit_q == STOP_LAST) begin
              bit_d   = '0;
              out_d   = shift_q;
              perr_d  = perr_calc_s;
              ferr_d  = facc_q | ~maj_s;
              ready_d = 1'b1;
              hold_d  = ~maj_s;
              state_d = ST_IDLE;
            end else begin
              bit_d = bit_q + BIT_ONE;
            end
          end else begin
            state_d = ST_STOP;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else begin
      tick_d = tick_q;
    end
  end

  // state and output registers
  always_ff @(posedge ref_clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      facc_q  <= 1'b0;
      hold_q  <= 1'b0;
      out_q   <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ready_q <= 1'b0;
      bclk_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      facc_q  <= facc_d;
      hold_q  <= hold_d;
      out_q   <= out_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      ready_q <= ready_d;
      bclk_q  <= bclk_d;
    end
  end

  assign ready   = ready_q;
  assign bit_clk = bclk_q;
  assign out     = out_q;
  assign perr    = perr_q;
  assign ferr    = ferr_q;

endmodule

// File: tb/tb_uart_rx_framed.sv
// Bench for uart_rx_framed: dut_a uses defaults (inverted line, no parity, 1 stop),
// dut_b uses even parity, 2 stop bits and a standard line.
module tb_uart_rx_framed;

  localparam int NT = 8;

  typedef struct packed {
    logic [7:0] d;
    logic       p;
    logic       f;
  } rec_t;

  typedef struct {
    logic [7:0] data;
    logic       pb;
    logic       s2;
    logic [7:0] e_out;
    logic       e_perr;
    logic       e_ferr;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, samp, in_a, in_b;
  logic rdy_a, bclk_a, perr_a, ferr_a, rdy_b, bclk_b, perr_b, ferr_b;
  logic [7:0] out_a, out_b;

  uart_rx_framed #(.Oversample(3), .Width(8), .Parity(0), .Stop(1), .Invert(1)) dut_a (
    .ref_clk(clk), .reset(rst), .samp_clk(samp), .in(in_a),
    .ready(rdy_a), .bit_clk(bclk_a), .out(out_a), .perr(perr_a), .ferr(ferr_a));

  uart_rx_framed #(.Oversample(3), .Width(8), .Parity(2), .Stop(2), .Invert(0)) dut_b (
    .ref_clk(clk), .reset(rst), .samp_clk(samp), .in(in_b),
    .ready(rdy_b), .bit_clk(bclk_b), .out(out_b), .perr(perr_b), .ferr(ferr_b));

  rec_t got_a[$], got_b[$], exp_a[$], exp_b[$];
  int   nbclk_a = 0;
  int   total = 0, bad = 0;
  int   rd_a = 0, rd_b = 0;

  // capture every completed frame and count bit_clk pulses
  always @(negedge clk) begin
    if (rdy_a) got_a.push_back('{d: out_a, p: perr_a, f: ferr_a});
    if (rdy_b) got_b.push_back('{d: out_b, p: perr_b, f: ferr_b});
    if (bclk_a) nbclk_a++;
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", nm, got, want);
    end
  endtask

  task automatic cmp_recs(input string nm, input rec_t got[$], input rec_t want[$], inout int rd);
    chk({nm, " frame count"}, 32'(got.size()), 32'(want.size()));
    while (rd < want.size()) begin
      if (rd < got.size()) begin
        chk({nm, " out"},  32'(got[rd].d), 32'(want[rd].d));
        chk({nm, " perr"}, 32'(got[rd].p), 32'(want[rd].p));
        chk({nm, " ferr"}, 32'(got[rd].f), 32'(want[rd].f));
      end
      rd++;
    end
  endtask

  // expected result of a frame, straight from the framing rules
  function automatic rec_t model(input logic [7:0] d, input int par, input logic pb,
                                 input logic s1, input logic s2, input int nstop);
    rec_t r;
    logic x;
    x   = (^d) ^ pb;
    r.d = d;
    r.p = (par == 1) ? ~x : ((par == 2) ? x : 1'b0);
    r.f = ~s1 | ((nstop == 2) ? ~s2 : 1'b0);
    return r;
  endfunction

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      int gap;
      gap = ($urandom_range(0, 15) == 0) ? 12 : int'($urandom_range(1, 3));
      samp = 1'b0;
      repeat (gap) @(negedge clk);
      samp = 1'b1;
      @(negedge clk);
      samp = 1'b0;
    end
  endtask

  // lv is the logical level: 1 idle/stop, 0 start
  task automatic send_bit(input int which, input logic lv, input int nbits);
    if (which == 0) in_a = ~lv;
    else            in_b = lv;
    ticks(NT * nbits);
  endtask

  task automatic send_frame(input int which, input logic [7:0] d, input logic pb,
                            input logic s1, input logic s2);
    send_bit(which, 1'b0, 1);
    for (int i = 0; i < 8; i++) send_bit(which, d[i], 1);
    if (which == 1) send_bit(which, pb, 1);
    send_bit(which, s1, 1);
    if (which == 1) send_bit(which, s2, 1);
  endtask

  vec_t tbl[7];
  logic [7:0] frames34[3];

  initial begin
    tbl[0] = '{8'h55, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0};
    tbl[1] = '{8'h55, 1'b1, 1'b1, 8'h55, 1'b1, 1'b0};
    tbl[2] = '{8'hAA, 1'b0, 1'b0, 8'hAA, 1'b0, 1'b1};
    tbl[3] = '{8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
    tbl[4] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0};
    tbl[5] = '{8'h01, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0};
    tbl[6] = '{8'h80, 1'b0, 1'b1, 8'h80, 1'b1, 1'b0};
    frames34[0] = 8'hAC; frames34[1] = 8'h93; frames34[2] = 8'h4D;

    rst = 1'b1; samp = 1'b0; in_a = 1'b0; in_b = 1'b1;
    repeat (2) @(negedge clk);
    ticks(2);
    rst = 1'b0;
    ticks(2);
    chk("reset ready_a", 32'(rdy_a), 32'd0);
    chk("reset out_a",   32'(out_a), 32'd0);
    chk("reset perr_a",  32'(perr_a), 32'd0);
    chk("reset ferr_a",  32'(ferr_a), 32'd0);
    chk("reset bitclk_a", 32'(bclk_a), 32'd0);
    chk("reset ready_b", 32'(rdy_b), 32'd0);
    chk("reset out_b",   32'(out_b), 32'd0);
    chk("reset perr_b",  32'(perr_b), 32'd0);
    chk("reset ferr_b",  32'(ferr_b), 32'd0);

    // three back-to-back frames
    begin
      int base;
      base = nbclk_a;
      for (int i = 0; i < 3; i++) begin
        send_frame(0, frames34[i], 1'b0, 1'b1, 1'b1);
        exp_a.push_back(model(frames34[i], 0, 1'b0, 1'b1, 1'b1, 1));
      end
      send_bit(0, 1'b1, 2);
      cmp_recs("b2b", got_a, exp_a, rd_a);
      chk("b2b bit_clk pulses", 32'(nbclk_a - base), 32'd24);
    end

    // short glitch at start level, then a good frame
    send_bit(0, 1'b0, 0);
    ticks(3);
    send_bit(0, 1'b1, 3);
    cmp_recs("glitch", got_a, exp_a, rd_a);
    send_frame(0, 8'h12, 1'b0, 1'b1, 1'b1);
    exp_a.push_back(model(8'h12, 0, 1'b0, 1'b1, 1'b1, 1));
    send_bit(0, 1'b1, 1);
    cmp_recs("after glitch", got_a, exp_a, rd_a);

    // bad stop followed by a long break; only the framed word may appear
    send_frame(0, 8'h5A, 1'b0, 1'b0, 1'b1);
    exp_a.push_back(model(8'h5A, 0, 1'b0, 1'b0, 1'b1, 1));
    send_bit(0, 1'b0, 12);
    send_bit(0, 1'b1, 2);
    send_frame(0, 8'h3C, 1'b0, 1'b1, 1'b1);
    exp_a.push_back(model(8'h3C, 0, 1'b0, 1'b1, 1'b1, 1));
    send_bit(0, 1'b1, 1);
    cmp_recs("break", got_a, exp_a, rd_a);

    // table: parity and stop-bit vectors on dut_b
    for (int i = 0; i < 7; i++) begin
      send_frame(1, tbl[i].data, tbl[i].pb, 1'b1, tbl[i].s2);
      send_bit(1, 1'b1, 2);
      exp_b.push_back('{d: tbl[i].e_out, p: tbl[i].e_perr, f: tbl[i].e_ferr});
      cmp_recs($sformatf("tbl%0d", i), got_b, exp_b, rd_b);
    end

    // reset after the fourth data bit aborts the frame
    send_bit(0, 1'b0, 1);
    for (int i = 0; i < 4; i++) send_bit(0, 1'(8'h12 >> i), 1);
    in_a = 1'b0;
    rst = 1'b1;
    ticks(2);
    rst = 1'b0;
    send_bit(0, 1'b1, 2);
    chk("abort out_a", 32'(out_a), 32'd0);
    cmp_recs("abort", got_a, exp_a, rd_a);
    send_frame(0, 8'h01, 1'b0, 1'b1, 1'b1);
    exp_a.push_back(model(8'h01, 0, 1'b0, 1'b1, 1'b1, 1));
    send_bit(0, 1'b1, 1);
    cmp_recs("post abort", got_a, exp_a, rd_a);

    // randomized frames against the model
    for (int i = 0; i < 12; i++) begin
      logic [7:0] d;
      logic s1;
      d  = 8'($urandom);
      s1 = ($urandom_range(0, 5) != 0);
      send_frame(0, d, 1'b0, s1, 1'b1);
      exp_a.push_back(model(d, 0, 1'b0, s1, 1'b1, 1));
      if (!s1 || $urandom_range(0, 1) == 0) send_bit(0, 1'b1, 1);
    end
    send_bit(0, 1'b1, 1);
    cmp_recs("rand a", got_a, exp_a, rd_a);

    for (int i = 0; i < 12; i++) begin
      logic [7:0] d;
      logic pb, s1, s2;
      d  = 8'($urandom);
      pb = 1'($urandom);
      s1 = ($urandom_range(0, 5) != 0);
      s2 = ($urandom_range(0, 5) != 0);
      send_frame(1, d, pb, s1, s2);
      exp_b.push_back(model(d, 2, pb, s1, s2, 2));
      if (!s2 || $urandom_range(0, 1) == 0) send_bit(1, 1'b1, 1);
    end
    send_bit(1, 1'b1, 1);
    cmp_recs("rand b", got_b, exp_b, rd_b);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
